// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A interrupt acknowledge path.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INT_ASSERT,
    ACK1,
    WAIT_ACK,
    WAIT_INTA2,
    ACK2
  } state_e;

  localparam int          AEOI_BIT        = 1;
  localparam logic [2:0]  SPURIOUS_LEVEL  = 3'd7;
  localparam int          VECTOR_BASE_MSB = 7;
  localparam int          VECTOR_BASE_LSB = 3;

  function automatic logic [7:0] lvl_mask(input logic [2:0] lvl);
    return 8'b1 << lvl;
  endfunction

endpackage

// File: rtl/priority_resolver.sv
// Rotating-priority resolver: highest pending request and whether it outranks
// every in-service level. ptr_i names the current lowest-priority level.
module priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] req_i,
  input  logic [7:0] isr_i,
  input  logic [2:0] ptr_i,
  output logic       eligible_o,
  output logic [2:0] winner_o
);

  logic [3:0] req_rank;
  logic [3:0] isr_rank;
  logic [2:0] lvl;

  // Walk from lowest to highest priority so the last hit is the highest one.
  always_comb begin
    req_rank = 4'd8;
    isr_rank = 4'd8;
    winner_o = SPURIOUS_LEVEL;
    lvl      = '0;
    for (int i = 7; i >= 0; i--) begin
      lvl = ptr_i + 3'(i + 1);
      if (req_i[lvl]) begin
        req_rank = 4'(i);
        winner_o = lvl;
      end
      if (isr_i[lvl]) isr_rank = 4'(i);
    end
    eligible_o = (req_rank < isr_rank);
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259A INT/INTA sequencer: priority vs ISR, two-pulse INTA, vector, EOI.
// Define AUTO_EOI_EN to honour ICW4 AEOI (ISR cleared at the second INTA rise).
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter bit PRIORITY_ROTATE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] risedBits,
  input  logic [7:0] ICW2,
  input  logic [7:0] ICW4,
  input  logic       interruptAck_n,
  input  logic       eoiCmd,
  input  logic       eoiSpecific,
  input  logic [2:0] eoiLevel,
  input  logic       readPriorityAck,
  output logic       INT,
  output logic       readPriority,
  output logic [2:0] resetIRR,
  output logic [7:0] ISR,
  output logic [7:0] dataBus,
  output logic       dataBusEn
);

  state_e     state_q;
  logic       int_q, rdpri_q, dben_q;
  logic       inta_q, ack_q, ack_vld_q, win_real_q;
  logic [2:0] rirr_q, ptr_q, win_q;
  logic [7:0] isr_q, db_q;

  logic       eoi_any, eoi_hit_d, req_elig, aeoi_en;
  logic [2:0] eoi_hi, eoi_lvl_d, req_win, ptr_d;
  logic [7:0] isr_d;
  logic       inta_fall, inta_rise, ack_tog;
  logic       unused_icw2;

  assign unused_icw2 = ^ICW2[VECTOR_BASE_LSB-1:0];

`ifdef AUTO_EOI_EN
  assign aeoi_en = ICW4[AEOI_BIT];
`else
  logic unused_icw4;
  assign aeoi_en     = 1'b0;
  assign unused_icw4 = ^ICW4;
`endif

  // Same resolver with no ISR masking finds the highest in-service level.
  priority_resolver u_eoi_res (
    .req_i     (isr_q),
    .isr_i     (8'h00),
    .ptr_i     (ptr_q),
    .eligible_o(eoi_any),
    .winner_o  (eoi_hi)
  );

  always_comb begin
    eoi_lvl_d = eoiSpecific ? eoiLevel : eoi_hi;
    eoi_hit_d = eoiCmd & (eoiSpecific ? isr_q[eoiLevel] : eoi_any);
    isr_d     = isr_q;
    ptr_d     = ptr_q;
    if (eoi_hit_d) begin
      isr_d = isr_q & ~lvl_mask(eoi_lvl_d);
      if (PRIORITY_ROTATE) ptr_d = eoi_lvl_d;
    end
  end

  // Requests are resolved against the post-EOI ISR and pointer.
  priority_resolver u_req_res (
    .req_i     (risedBits),
    .isr_i     (isr_d),
    .ptr_i     (ptr_d),
    .eligible_o(req_elig),
    .winner_o  (req_win)
  );

  assign inta_fall = inta_q & ~interruptAck_n;
  assign inta_rise = ~inta_q & interruptAck_n;
  assign ack_tog   = ack_vld_q & (ack_q ^ readPriorityAck);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      int_q      <= 1'b0;
      rdpri_q    <= 1'b0;
      dben_q     <= 1'b0;
      db_q       <= '0;
      rirr_q     <= '0;
      isr_q      <= '0;
      ptr_q      <= 3'd7;
      win_q      <= SPURIOUS_LEVEL;
      win_real_q <= 1'b0;
      inta_q     <= 1'b1;
      ack_q      <= 1'b0;
      ack_vld_q  <= 1'b0;
    end else begin
      inta_q    <= interruptAck_n;
      ack_q     <= readPriorityAck;
      ack_vld_q <= 1'b1;
      isr_q     <= isr_d;
      ptr_q     <= ptr_d;
      if (rdpri_q && ack_tog) rdpri_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (req_elig) begin
            int_q   <= 1'b1;
            state_q <= INT_ASSERT;
          end
        end
        INT_ASSERT: begin
          if (inta_fall) begin
            int_q   <= 1'b0;
            state_q <= ACK1;
          end
        end
        ACK1: begin
          win_real_q <= req_elig;
          state_q    <= WAIT_ACK;
          if (req_elig) begin
            win_q   <= req_win;
            isr_q   <= isr_d | lvl_mask(req_win);
            rirr_q  <= req_win;
            rdpri_q <= 1'b1;
          end else begin
            win_q <= SPURIOUS_LEVEL;
          end
        end
        WAIT_ACK: begin
          if (interruptAck_n) state_q <= WAIT_INTA2;
        end
        WAIT_INTA2: begin
          if (inta_fall) begin
            db_q    <= {ICW2[VECTOR_BASE_MSB:VECTOR_BASE_LSB], win_q};
            dben_q  <= 1'b1;
            state_q <= ACK2;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            db_q    <= '0;
            dben_q  <= 1'b0;
            state_q <= IDLE;
            if (aeoi_en && win_real_q) begin
              isr_q <= isr_d & ~lvl_mask(win_q);
              if (PRIORITY_ROTATE) ptr_q <= win_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign INT          = int_q;
  assign readPriority = rdpri_q;
  assign resetIRR     = rirr_q;
  assign ISR          = isr_q;
  assign dataBus      = db_q;
  assign dataBusEn    = dben_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Bench: fixed and rotating-priority instances share stimulus; each is checked
// against a priority/ISR model built from level ordering arithmetic.
module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] risedBits, ICW2, ICW4;
  logic       interruptAck_n, eoiCmd, eoiSpecific;
  logic [2:0] eoiLevel;
  logic       ack [2];

  logic       int_o [2];
  logic       rp_o  [2];
  logic       dbe_o [2];
  logic [2:0] rirr_o[2];
  logic [7:0] isr_o [2];
  logic [7:0] db_o  [2];

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] isr_m [2];
  int         ptr_m [2];
  bit         rot   [2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  interrupt_ack_sequencer #(.PRIORITY_ROTATE(1'b0)) u_fix (
    .clk(clk), .reset(reset), .risedBits(risedBits), .ICW2(ICW2), .ICW4(ICW4),
    .interruptAck_n(interruptAck_n), .eoiCmd(eoiCmd), .eoiSpecific(eoiSpecific),
    .eoiLevel(eoiLevel), .readPriorityAck(ack[0]), .INT(int_o[0]),
    .readPriority(rp_o[0]), .resetIRR(rirr_o[0]), .ISR(isr_o[0]),
    .dataBus(db_o[0]), .dataBusEn(dbe_o[0]));

  interrupt_ack_sequencer #(.PRIORITY_ROTATE(1'b1)) u_rot (
    .clk(clk), .reset(reset), .risedBits(risedBits), .ICW2(ICW2), .ICW4(ICW4),
    .interruptAck_n(interruptAck_n), .eoiCmd(eoiCmd), .eoiSpecific(eoiSpecific),
    .eoiLevel(eoiLevel), .readPriorityAck(ack[1]), .INT(int_o[1]),
    .readPriority(rp_o[1]), .resetIRR(rirr_o[1]), .ISR(isr_o[1]),
    .dataBus(db_o[1]), .dataBusEn(dbe_o[1]));

  // ptr is the lowest-priority level; ptr+1 is the highest.
  function automatic int hi_level(input logic [7:0] bits, input int p);
    for (int k = 1; k <= 8; k++) if (bits[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic int rank(input int lvl, input int p);
    return (lvl - p - 1 + 16) % 8;
  endfunction

  function automatic bit elig(input logic [7:0] r, input logic [7:0] s, input int p);
    int hr, hs;
    hr = hi_level(r, p);
    hs = hi_level(s, p);
    if (hr < 0) return 1'b0;
    if (hs < 0) return 1'b1;
    return rank(hr, p) < rank(hs, p);
  endfunction

  function automatic bit aeoi_on();
`ifdef AUTO_EOI_EN
    return ICW4[1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      isr_m[d] = 8'h00;
      ptr_m[d] = 7;
    end
    tick();
  endtask

  task automatic test_reset();
    risedBits = 8'h00; ICW2 = 8'h40; ICW4 = 8'h00; interruptAck_n = 1'b1;
    eoiCmd = 1'b0; eoiSpecific = 1'b0; eoiLevel = 3'd0; ack[0] = 1'b0; ack[1] = 1'b0;
    reset = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({int_o[d], rp_o[d], rirr_o[d], isr_o[d], db_o[d], dbe_o[d]} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d got INT=%b rp=%b rirr=%0d isr=%h db=%h dbe=%b want all 0",
                 d, int_o[d], rp_o[d], rirr_o[d], isr_o[d], db_o[d], dbe_o[d]);
      end
    end
    do_reset();
  endtask

  // Full INTA1/INTA2 sequence; drop clears requests after INT (spurious case).
  task automatic run_cycle(input logic [7:0] req, input bit drop);
    bit   act[2];
    bit   real_w[2];
    int   w[2];
    logic [7:0] vec;
    risedBits = req;
    tick();
    for (int d = 0; d < 2; d++) begin
      act[d] = elig(req, isr_m[d], ptr_m[d]);
      n_chk++;
      if (int_o[d] !== act[d]) begin
        n_fail++; $display("FAIL int_rise dut%0d got %b want %b", d, int_o[d], act[d]);
      end
    end
    if (drop) risedBits = 8'h00;
    interruptAck_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (int_o[d] !== 1'b0) begin
        n_fail++; $display("FAIL int_fall dut%0d got %b want 0", d, int_o[d]);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      real_w[d] = act[d] && elig(risedBits, isr_m[d], ptr_m[d]);
      w[d] = real_w[d] ? hi_level(risedBits, ptr_m[d]) : 7;
      if (real_w[d]) isr_m[d][w[d]] = 1'b1;
      n_chk++;
      if (isr_o[d] !== isr_m[d] || rp_o[d] !== real_w[d] ||
          (real_w[d] && rirr_o[d] !== 3'(w[d]))) begin
        n_fail++;
        $display("FAIL ack1 dut%0d got isr=%h rp=%b rirr=%0d want isr=%h rp=%b rirr=%0d",
                 d, isr_o[d], rp_o[d], rirr_o[d], isr_m[d], real_w[d], w[d]);
      end
    end
    interruptAck_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (rp_o[d] !== real_w[d]) begin
        n_fail++; $display("FAIL rp_hold dut%0d got %b want %b", d, rp_o[d], real_w[d]);
      end
      if (real_w[d]) ack[d] = ~ack[d];
    end
    interruptAck_n = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      vec = {ICW2[7:3], 3'(w[d])};
      n_chk++;
      if (dbe_o[d] !== act[d] || (act[d] && db_o[d] !== vec)) begin
        n_fail++;
        $display("FAIL vector dut%0d got dbe=%b db=%h want dbe=%b db=%h",
                 d, dbe_o[d], db_o[d], act[d], vec);
      end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (rp_o[d] !== 1'b0) begin
        n_fail++; $display("FAIL rp_drop dut%0d got %b want 0", d, rp_o[d]);
      end
    end
    interruptAck_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      if (act[d] && real_w[d] && aeoi_on()) begin
        isr_m[d][w[d]] = 1'b0;
        if (rot[d]) ptr_m[d] = w[d];
      end
      n_chk++;
      if (dbe_o[d] !== 1'b0 || isr_o[d] !== isr_m[d]) begin
        n_fail++;
        $display("FAIL ack2_end dut%0d got dbe=%b isr=%h want dbe=0 isr=%h",
                 d, dbe_o[d], isr_o[d], isr_m[d]);
      end
    end
    risedBits = 8'h00;
  endtask

  task automatic do_eoi(input bit spec, input logic [2:0] lvl);
    int h;
    eoiCmd = 1'b1; eoiSpecific = spec; eoiLevel = lvl;
    tick();
    eoiCmd = 1'b0;
    for (int d = 0; d < 2; d++) begin
      h = spec ? (isr_m[d][lvl] ? int'(lvl) : -1) : hi_level(isr_m[d], ptr_m[d]);
      if (h >= 0) begin
        isr_m[d][h] = 1'b0;
        if (rot[d]) ptr_m[d] = h;
      end
      n_chk++;
      if (isr_o[d] !== isr_m[d]) begin
        n_fail++; $display("FAIL eoi dut%0d got isr=%h want %h", d, isr_o[d], isr_m[d]);
      end
    end
  endtask

  task automatic test_basic();
    ICW2 = 8'h40;
    run_cycle(8'h28, 1'b0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (isr_o[d] !== 8'h08) begin
        n_fail++; $display("FAIL basic_isr dut%0d got %h want 08", d, isr_o[d]);
      end
    end
  endtask

  task automatic test_nesting();
    do_reset();
    run_cycle(8'h04, 1'b0);
    risedBits = 8'h10;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (int_o[d] !== 1'b0) begin
        n_fail++; $display("FAIL nest_block dut%0d got INT=%b want 0", d, int_o[d]);
      end
    end
    run_cycle(8'h02, 1'b0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (isr_o[d] !== 8'h06) begin
        n_fail++; $display("FAIL nest_isr dut%0d got %h want 06", d, isr_o[d]);
      end
    end
  endtask

  task automatic test_spurious();
    do_reset();
    ICW2 = 8'hA8;
    run_cycle(8'h01, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (isr_o[d] !== 8'h00) begin
        n_fail++; $display("FAIL spurious_isr dut%0d got %h want 00", d, isr_o[d]);
      end
    end
    ICW2 = 8'h40;
  endtask

  task automatic test_eoi();
    do_reset();
    do_eoi(1'b0, 3'd0);
    run_cycle(8'h08, 1'b0);
    run_cycle(8'h02, 1'b0);
    do_eoi(1'b0, 3'd0);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (isr_o[d] !== 8'h08) begin
        n_fail++; $display("FAIL eoi_nonspec dut%0d got %h want 08", d, isr_o[d]);
      end
    end
    do_eoi(1'b1, 3'd3);
    run_cycle(8'h18, 1'b0);
    n_chk++;
    if (isr_o[0] !== 8'h08 || isr_o[1] !== 8'h10) begin
      n_fail++;
      $display("FAIL rotate_order got fix=%h rot=%h want fix=08 rot=10", isr_o[0], isr_o[1]);
    end
  endtask

  task automatic test_aeoi();
    do_reset();
    ICW4 = 8'h02;
    run_cycle(8'h40, 1'b0);
    run_cycle(8'h02, 1'b0);
    ICW4 = 8'h00;
  endtask

  task automatic test_reset_wait_ack();
    do_reset();
    risedBits = 8'h20;
    tick();
    interruptAck_n = 1'b0;
    tick();
    tick();
    n_chk++;
    if (rp_o[0] !== 1'b1 || rp_o[1] !== 1'b1) begin
      n_fail++; $display("FAIL wait_ack_rp got %b %b want 1 1", rp_o[0], rp_o[1]);
    end
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({int_o[d], rp_o[d], rirr_o[d], isr_o[d], db_o[d], dbe_o[d]} !== 22'd0) begin
        n_fail++;
        $display("FAIL midreset dut%0d got INT=%b rp=%b rirr=%0d isr=%h db=%h dbe=%b want all 0",
                 d, int_o[d], rp_o[d], rirr_o[d], isr_o[d], db_o[d], dbe_o[d]);
      end
    end
    risedBits = 8'h00;
    interruptAck_n = 1'b1;
    tick();
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      isr_m[d] = 8'h00;
      ptr_m[d] = 7;
    end
    tick();
    run_cycle(8'h20, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] req;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      req = 8'($urandom_range(0, 255));
      ICW2 = 8'($urandom_range(0, 255));
      run_cycle(req, 1'b0);
      if ($urandom_range(0, 1) == 1)
        do_eoi(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_spurious();
    test_eoi();
    test_aeoi();
    test_reset_wait_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
